regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / Write_register / Write_data) between two write-back requesters: the memory-load path and the ALU path.
- Memory has fixed priority and is never back-pressured. ALU results that lose arbitration are held in a small FIFO.
- Provides pending-write flags so decode/hazard logic can stall reads of registers with writes still in flight.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing one register-file write port between the memory-load path
// (fixed priority) and the ALU path (buffered in a small FIFO), with hazard pending flags.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_reg,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_reg,
   input  logic [DATA_W-1:0] alu_data,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] Write_register,
   output logic [DATA_W-1:0] Write_data,
   input  logic [ADDR_W-1:0] query_reg_1,
   input  logic [ADDR_W-1:0] query_reg_2,
   output logic              pending_1,
   output logic              pending_2,
   output logic              busy,
   output logic [15:0]       stall_cnt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_fifo_reg  [DEPTH];
   logic [DATA_W-1:0] r_fifo_data [DEPTH];
   logic [DEPTH-1:0]  r_fifo_vld;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              r_reg_write;
   logic [ADDR_W-1:0] r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;
   logic [15:0]       r_stall_cnt;

   logic              w_fifo_ne;
   logic              w_fifo_full;
   logic              w_mem_issue;
   logic              w_alu_take;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;
   logic              w_issue;
   logic [ADDR_W-1:0] w_issue_reg;
   logic [DATA_W-1:0] w_issue_data;
   logic              w_pend_1;
   logic              w_pend_2;

   assign w_fifo_ne   = (r_count != '0);
   assign w_fifo_full = (r_count == CNT_W'(DEPTH));

   assign mem_ready = !reset;
   assign alu_ready = !reset && (!w_fifo_full || !mem_valid);

   // Register-0 requests are accepted but never occupy the issue slot or a FIFO entry.
   assign w_mem_issue = mem_valid && mem_ready && (mem_reg != '0);
   assign w_alu_take  = alu_valid && alu_ready && (alu_reg != '0);
   assign w_pop       = !w_mem_issue && w_fifo_ne;
   assign w_bypass    = w_alu_take && !w_mem_issue && !w_fifo_ne;
   assign w_push      = w_alu_take && !w_bypass;

   always_comb begin
      w_issue      = 1'b0;
      w_issue_reg  = '0;
      w_issue_data = '0;
      if (w_mem_issue) begin
         w_issue      = 1'b1;
         w_issue_reg  = mem_reg;
         w_issue_data = mem_data;
      end else if (w_fifo_ne) begin
         w_issue      = 1'b1;
         w_issue_reg  = r_fifo_reg[r_rd_ptr];
         w_issue_data = r_fifo_data[r_rd_ptr];
      end else if (w_bypass) begin
         w_issue      = 1'b1;
         w_issue_reg  = alu_reg;
         w_issue_data = alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_reg[r_wr_ptr]  <= alu_reg;
         r_fifo_data[r_wr_ptr] <= alu_data;
      end
   end

   // FIFO control; on a full push+pop the same slot is cleared then re-marked valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_fifo_vld <= '0;
      end else begin
         if (w_pop) begin
            r_fifo_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr             <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push) begin
            r_fifo_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg_write <= 1'b0;
         r_wr_reg    <= '0;
         r_wr_data   <= '0;
      end else begin
         r_reg_write <= w_issue;
         if (w_issue) begin
            r_wr_reg  <= w_issue_reg;
            r_wr_data <= w_issue_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (alu_valid && !alu_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // A register is pending while it sits in the FIFO or is on the write port this cycle.
   always_comb begin
      w_pend_1 = r_reg_write && (r_wr_reg == query_reg_1);
      w_pend_2 = r_reg_write && (r_wr_reg == query_reg_2);
      for (int i = 0; i < DEPTH; i++) begin
         if (r_fifo_vld[i] && (r_fifo_reg[i] == query_reg_1)) w_pend_1 = 1'b1;
         if (r_fifo_vld[i] && (r_fifo_reg[i] == query_reg_2)) w_pend_2 = 1'b1;
      end
      if (query_reg_1 == '0) w_pend_1 = 1'b0;
      if (query_reg_2 == '0) w_pend_2 = 1'b0;
   end

   assign pending_1      = w_pend_1;
   assign pending_2      = w_pend_2;
   assign busy           = w_fifo_ne || r_reg_write;
   assign RegWrite       = r_reg_write;
   assign Write_register = r_wr_reg;
   assign Write_data     = r_wr_data;
   assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed expectations checked with immediate assertions.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_reg;
   logic [31:0] mem_data;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        RegWrite;
   logic [4:0]  Write_register;
   logic [31:0] Write_data;
   logic [4:0]  query_reg_1;
   logic [4:0]  query_reg_2;
   logic        pending_1;
   logic        pending_2;
   logic        busy;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_reg        (mem_reg),
      .mem_data       (mem_data),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_reg        (alu_reg),
      .alu_data       (alu_data),
      .RegWrite       (RegWrite),
      .Write_register (Write_register),
      .Write_data     (Write_data),
      .query_reg_1    (query_reg_1),
      .query_reg_2    (query_reg_2),
      .pending_1      (pending_1),
      .pending_2      (pending_2),
      .busy           (busy),
      .stall_cnt      (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic v, input logic [4:0] r, input logic [31:0] d);
      mem_valid = v;
      mem_reg   = r;
      mem_data  = d;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
      alu_valid = v;
      alu_reg   = r;
      alu_data  = d;
   endtask

   initial begin
      reset = 1'b1;
      set_mem(1'b0, 5'd0, 32'h0);
      set_alu(1'b1, 5'd9, 32'h99);
      query_reg_1 = 5'd0;
      query_reg_2 = 5'd0;
      #1;
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_alu_ready", 32'(alu_ready), 32'd0);
      tick();
      tick();
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_wreg", 32'(Write_register), 32'd0);
      chk("rst_wdata", Write_data, 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      reset = 1'b0;
      set_alu(1'b0, 5'd0, 32'h0);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mem_ready", 32'(mem_ready), 32'd1);
      chk("idle_alu_ready", 32'(alu_ready), 32'd1);

      // ALU only: one-cycle bypass
      set_alu(1'b1, 5'd3, 32'h7);
      query_reg_1 = 5'd3;
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("alu_rw", 32'(RegWrite), 32'd1);
      chk("alu_wreg", 32'(Write_register), 32'd3);
      chk("alu_wdata", Write_data, 32'h7);
      chk("alu_pend", 32'(pending_1), 32'd1);
      chk("alu_busy", 32'(busy), 32'd1);
      tick();
      chk("alu_rw_off", 32'(RegWrite), 32'd0);
      chk("alu_pend_off", 32'(pending_1), 32'd0);
      chk("alu_wreg_hold", 32'(Write_register), 32'd3);

      // Collision: memory first, ALU queued
      set_mem(1'b1, 5'd5, 32'hA);
      set_alu(1'b1, 5'd6, 32'hB);
      query_reg_1 = 5'd6;
      query_reg_2 = 5'd5;
      #1;
      chk("col_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      set_mem(1'b0, 5'd0, 32'h0);
      set_alu(1'b0, 5'd0, 32'h0);
      chk("col1_wreg", 32'(Write_register), 32'd5);
      chk("col1_wdata", Write_data, 32'hA);
      chk("col1_busy", 32'(busy), 32'd1);
      chk("col1_pend_fifo", 32'(pending_1), 32'd1);
      chk("col1_pend_wp", 32'(pending_2), 32'd1);
      tick();
      chk("col2_rw", 32'(RegWrite), 32'd1);
      chk("col2_wreg", 32'(Write_register), 32'd6);
      chk("col2_wdata", Write_data, 32'hB);
      chk("col2_busy", 32'(busy), 32'd1);
      chk("col2_pend_mem_done", 32'(pending_2), 32'd0);
      tick();
      chk("col3_rw", 32'(RegWrite), 32'd0);
      chk("col3_busy", 32'(busy), 32'd0);

      // Back-pressure: memory held for 4 edges while ALU streams 1,2,3
      query_reg_1 = 5'd1;
      query_reg_2 = 5'd2;
      set_mem(1'b1, 5'd10, 32'h100);
      set_alu(1'b1, 5'd1, 32'h11);
      #1;
      chk("bp1_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      chk("bp1_wreg", 32'(Write_register), 32'd10);
      set_mem(1'b1, 5'd11, 32'h101);
      set_alu(1'b1, 5'd2, 32'h22);
      #1;
      chk("bp2_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      chk("bp2_wreg", 32'(Write_register), 32'd11);
      set_mem(1'b1, 5'd12, 32'h102);
      set_alu(1'b1, 5'd3, 32'h33);
      #1;
      chk("bp3_alu_ready", 32'(alu_ready), 32'd0);
      tick();
      chk("bp3_wreg", 32'(Write_register), 32'd12);
      chk("bp3_stall", 32'(stall_cnt), 32'd1);
      chk("bp3_pend1", 32'(pending_1), 32'd1);
      chk("bp3_pend2", 32'(pending_2), 32'd1);
      set_mem(1'b1, 5'd13, 32'h103);
      #1;
      chk("bp4_alu_ready", 32'(alu_ready), 32'd0);
      tick();
      chk("bp4_wdata", Write_data, 32'h103);
      chk("bp4_stall", 32'(stall_cnt), 32'd2);
      // FIFO full, memory idle: simultaneous push and pop
      set_mem(1'b0, 5'd0, 32'h0);
      query_reg_2 = 5'd3;
      #1;
      chk("full_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("drain1_wreg", 32'(Write_register), 32'd1);
      chk("drain1_wdata", Write_data, 32'h11);
      chk("drain1_stall", 32'(stall_cnt), 32'd2);
      chk("drain1_pend3", 32'(pending_2), 32'd1);
      tick();
      chk("drain2_wreg", 32'(Write_register), 32'd2);
      chk("drain2_wdata", Write_data, 32'h22);
      chk("drain2_busy", 32'(busy), 32'd1);
      tick();
      chk("drain3_wreg", 32'(Write_register), 32'd3);
      chk("drain3_wdata", Write_data, 32'h33);
      tick();
      chk("drain4_rw", 32'(RegWrite), 32'd0);
      chk("drain4_busy", 32'(busy), 32'd0);

      // Register 0: memory reg 0 lets the FIFO head through on the same edge
      set_mem(1'b1, 5'd20, 32'h200);
      set_alu(1'b1, 5'd4, 32'h44);
      tick();
      chk("r0a_wreg", 32'(Write_register), 32'd20);
      set_mem(1'b1, 5'd0, 32'hDEAD);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      set_mem(1'b0, 5'd0, 32'h0);
      chk("r0b_rw", 32'(RegWrite), 32'd1);
      chk("r0b_wreg", 32'(Write_register), 32'd4);
      chk("r0b_wdata", Write_data, 32'h44);
      tick();
      chk("r0c_rw", 32'(RegWrite), 32'd0);
      set_alu(1'b1, 5'd0, 32'hBEEF);
      query_reg_1 = 5'd0;
      #1;
      chk("r0d_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("r0d_rw", 32'(RegWrite), 32'd0);
      chk("r0d_busy", 32'(busy), 32'd0);
      chk("r0d_wreg_hold", 32'(Write_register), 32'd4);
      chk("r0d_pend_zero", 32'(pending_1), 32'd0);

      // Mid-operation reset with two FIFO entries
      set_mem(1'b1, 5'd21, 32'h210);
      set_alu(1'b1, 5'd7, 32'h77);
      tick();
      set_mem(1'b1, 5'd22, 32'h220);
      set_alu(1'b1, 5'd8, 32'h88);
      tick();
      set_mem(1'b1, 5'd23, 32'h230);
      set_alu(1'b1, 5'd9, 32'h99);
      query_reg_1 = 5'd7;
      query_reg_2 = 5'd8;
      #1;
      chk("mr_pre_pend1", 32'(pending_1), 32'd1);
      chk("mr_pre_pend2", 32'(pending_2), 32'd1);
      tick();
      chk("mr_pre_stall", 32'(stall_cnt), 32'd3);
      reset = 1'b1;
      set_mem(1'b0, 5'd0, 32'h0);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      chk("mr_rw", 32'(RegWrite), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_pend1", 32'(pending_1), 32'd0);
      chk("mr_pend2", 32'(pending_2), 32'd0);
      chk("mr_stall", 32'(stall_cnt), 32'd0);
      reset = 1'b0;
      tick();
      chk("mr_after_rw", 32'(RegWrite), 32'd0);
      chk("mr_after_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
